// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and issue-stage record for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic       owner;
        logic       we;
        logic [1:0] len;
        logic       err;
    } iss_cmd_t;

    // Loads treat LEN_NONE as a word, so it shares the default.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-requester grant logic: round-robin or fixed A-priority.
module dmem_rr_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic r_prio_b;
    logic w_pick_b;

    // B wins alone, or on a tie when it is B's turn in round-robin mode.
    assign w_pick_b = i_req_b &
                      (~i_req_a | (r_prio_b & (FIXED_PRIO == 0)));

    assign o_gnt_a = ~i_rst & i_req_a & ~w_pick_b;
    assign o_gnt_b = ~i_rst & w_pick_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio_b <= 1'b0;
        end else if (o_gnt_a) begin
            r_prio_b <= 1'b1;
        end else if (o_gnt_b) begin
            r_prio_b <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (A) and debug/loader (B) accesses onto one data memory
// through a one-deep issue stage with registered read responses.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAST_BYTE = 1024,
    parameter int          FIXED_PRIO    = 0
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        A_req,
    input  logic        A_we,
    input  logic [1:0]  A_len,
    input  logic        A_signed,
    input  logic [31:0] A_addr,
    input  logic [31:0] A_wdata,
    output logic        A_gnt,
    output logic        A_rvalid,
    output logic [31:0] A_rdata,
    output logic        A_err,
    input  logic        B_req,
    input  logic        B_we,
    input  logic [1:0]  B_len,
    input  logic        B_signed,
    input  logic [31:0] B_addr,
    input  logic [31:0] B_wdata,
    output logic        B_gnt,
    output logic        B_rvalid,
    output logic [31:0] B_rdata,
    output logic        B_err,
    output logic [1:0]  MEM_write_length,
    output logic [1:0]  MEM_read_length,
    output logic        MEM_read_signed,
    output logic [31:0] MEM_write_address,
    output logic [31:0] MEM_write_data,
    output logic [31:0] MEM_read_address,
    input  logic [31:0] MEM_read_data
);

    logic        w_we;
    logic [1:0]  w_len;
    logic        w_sgn;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_acc;
    logic [32:0] w_last;
    logic        w_oob;
    logic        w_err;
    logic        w_rsp_a;
    logic        w_rsp_b;

    iss_cmd_t    r_iss;
    logic        r_iss_vld;
    logic [1:0]  r_rd_len;
    logic        r_rd_sgn;
    logic [31:0] r_rd_addr;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_a_rvalid;
    logic        r_a_err;
    logic [31:0] r_a_rdata;
    logic        r_b_rvalid;
    logic        r_b_err;
    logic [31:0] r_b_rdata;

    dmem_rr_arb #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .i_clk  (SYS_clk),
        .i_rst  (SYS_reset),
        .i_req_a(A_req),
        .i_req_b(B_req),
        .o_gnt_a(A_gnt),
        .o_gnt_b(B_gnt)
    );

    always_comb begin
        w_we    = A_we;
        w_len   = A_len;
        w_sgn   = A_signed;
        w_addr  = A_addr;
        w_wdata = A_wdata;
        if (B_gnt) begin
            w_we    = B_we;
            w_len   = B_len;
            w_sgn   = B_signed;
            w_addr  = B_addr;
            w_wdata = B_wdata;
        end
    end

    // 33-bit end address so accesses near 2^32 cannot wrap into range.
    assign w_acc  = A_gnt | B_gnt;
    assign w_last = {1'b0, w_addr} + {30'd0, len_bytes(w_len)} - 33'd1;
    assign w_oob  = w_last > 33'(MEM_LAST_BYTE);
    assign w_err  = w_oob & ~(w_we & (w_len == LEN_NONE));

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_iss_vld <= 1'b0;
            r_iss     <= '0;
            r_rd_len  <= LEN_NONE;
            r_rd_sgn  <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_iss_vld <= w_acc;
            if (w_acc) begin
                r_iss.owner <= B_gnt ? PORT_B : PORT_A;
                r_iss.we    <= w_we;
                r_iss.len   <= w_len;
                r_iss.err   <= w_err;
                if (w_we) begin
                    r_wr_addr <= w_addr;
                    r_wr_data <= w_wdata;
                end else begin
                    r_rd_len  <= (w_len == LEN_NONE) ? LEN_WORD : w_len;
                    r_rd_sgn  <= w_sgn;
                    r_rd_addr <= w_addr;
                end
            end
        end
    end

    assign MEM_write_length  = (r_iss_vld & r_iss.we & ~r_iss.err) ?
                               r_iss.len : LEN_NONE;
    assign MEM_write_address = r_wr_addr;
    assign MEM_write_data    = r_wr_data;
    assign MEM_read_length   = r_rd_len;
    assign MEM_read_signed   = r_rd_sgn;
    assign MEM_read_address  = r_rd_addr;

    assign w_rsp_a = r_iss_vld & (r_iss.owner == PORT_A);
    assign w_rsp_b = r_iss_vld & (r_iss.owner == PORT_B);

    // Stores acknowledge without touching rdata; blocked accesses clear it.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_a_rvalid <= 1'b0;
            r_a_err    <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rvalid <= 1'b0;
            r_b_err    <= 1'b0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_rsp_a;
            r_a_err    <= w_rsp_a & r_iss.err;
            r_b_rvalid <= w_rsp_b;
            r_b_err    <= w_rsp_b & r_iss.err;
            if (w_rsp_a) begin
                if (r_iss.err) begin
                    r_a_rdata <= '0;
                end else if (!r_iss.we) begin
                    r_a_rdata <= MEM_read_data;
                end
            end
            if (w_rsp_b) begin
                if (r_iss.err) begin
                    r_b_rdata <= '0;
                end else if (!r_iss.we) begin
                    r_b_rdata <= MEM_read_data;
                end
            end
        end
    end

    assign A_rvalid = r_a_rvalid;
    assign A_err    = r_a_err;
    assign A_rdata  = r_a_rdata;
    assign B_rvalid = r_b_rvalid;
    assign B_err    = r_b_err;
    assign B_rdata  = r_b_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array memory model.
module tb_dmem_arbiter;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        A_req, A_we, A_signed;
    logic [1:0]  A_len;
    logic [31:0] A_addr, A_wdata;
    logic        A_gnt, A_rvalid, A_err;
    logic [31:0] A_rdata;
    logic        B_req, B_we, B_signed;
    logic [1:0]  B_len;
    logic [31:0] B_addr, B_wdata;
    logic        B_gnt, B_rvalid, B_err;
    logic [31:0] B_rdata;
    logic [1:0]  MEM_write_length, MEM_read_length;
    logic        MEM_read_signed;
    logic [31:0] MEM_write_address, MEM_write_data, MEM_read_address;
    logic [31:0] mem_rd;

    logic        f_a_req, f_b_req;
    logic        z1;
    logic [1:0]  z2;
    logic [31:0] z32;
    logic        fx_a_gnt, fx_a_rvalid, fx_a_err;
    logic        fx_b_gnt, fx_b_rvalid, fx_b_err;
    logic [31:0] fx_a_rdata, fx_b_rdata;
    logic [1:0]  fx_wlen, fx_rlen;
    logic        fx_rsgn;
    logic [31:0] fx_waddr, fx_wdata, fx_raddr;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          t;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    logic [7:0]  mem[0:2047];
    bit          mem_ready = 1'b0;
    int          wi;
    int          ri;
    logic [31:0] rw;

    always #5 SYS_clk = ~SYS_clk;
    always @(posedge SYS_clk) cyc <= cyc + 1;

    dmem_arbiter #(.MEM_LAST_BYTE(1024), .FIXED_PRIO(0)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .A_req(A_req), .A_we(A_we), .A_len(A_len), .A_signed(A_signed),
        .A_addr(A_addr), .A_wdata(A_wdata), .A_gnt(A_gnt),
        .A_rvalid(A_rvalid), .A_rdata(A_rdata), .A_err(A_err),
        .B_req(B_req), .B_we(B_we), .B_len(B_len), .B_signed(B_signed),
        .B_addr(B_addr), .B_wdata(B_wdata), .B_gnt(B_gnt),
        .B_rvalid(B_rvalid), .B_rdata(B_rdata), .B_err(B_err),
        .MEM_write_length(MEM_write_length),
        .MEM_read_length(MEM_read_length),
        .MEM_read_signed(MEM_read_signed),
        .MEM_write_address(MEM_write_address),
        .MEM_write_data(MEM_write_data),
        .MEM_read_address(MEM_read_address),
        .MEM_read_data(mem_rd)
    );

    dmem_arbiter #(.MEM_LAST_BYTE(1024), .FIXED_PRIO(1)) u_fix (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .A_req(f_a_req), .A_we(z1), .A_len(z2), .A_signed(z1),
        .A_addr(z32), .A_wdata(z32), .A_gnt(fx_a_gnt),
        .A_rvalid(fx_a_rvalid), .A_rdata(fx_a_rdata), .A_err(fx_a_err),
        .B_req(f_b_req), .B_we(z1), .B_len(z2), .B_signed(z1),
        .B_addr(z32), .B_wdata(z32), .B_gnt(fx_b_gnt),
        .B_rvalid(fx_b_rvalid), .B_rdata(fx_b_rdata), .B_err(fx_b_err),
        .MEM_write_length(fx_wlen), .MEM_read_length(fx_rlen),
        .MEM_read_signed(fx_rsgn), .MEM_write_address(fx_waddr),
        .MEM_write_data(fx_wdata), .MEM_read_address(fx_raddr),
        .MEM_read_data(z32)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    always @(posedge SYS_clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else if (MEM_write_length != 2'b00 &&
                     MEM_write_address < 32'd2045) begin
            wi = int'(MEM_write_address);
            mem[wi] <= MEM_write_data[7:0];
            if (MEM_write_length != 2'b01) mem[wi+1] <= MEM_write_data[15:8];
            if (MEM_write_length == 2'b11) begin
                mem[wi+2] <= MEM_write_data[23:16];
                mem[wi+3] <= MEM_write_data[31:24];
            end
        end
    end

    always_comb begin
        ri = 0;
        rw = 32'h0;
        mem_rd = 32'h0;
        if (MEM_read_address < 32'd2045) begin
            ri = int'(MEM_read_address);
            rw = {mem[ri+3], mem[ri+2], mem[ri+1], mem[ri]};
        end
        case (MEM_read_length)
            2'b01: mem_rd = MEM_read_signed ? {{24{rw[7]}}, rw[7:0]}
                                            : {24'h0, rw[7:0]};
            2'b10: mem_rd = MEM_read_signed ? {{16{rw[15]}}, rw[15:0]}
                                            : {16'h0, rw[15:0]};
            default: mem_rd = rw;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'h0, act}, {31'h0, exp});
    endtask

    always @(negedge SYS_clk) begin
        if (!SYS_reset) begin
            if (A_rvalid) begin
                if (qa.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL a_unexp: rvalid rdata %h, expected none", A_rdata);
                end else begin
                    ea = qa.pop_front();
                    chk("a_rdata", A_rdata, ea.d);
                    chk1("a_err", A_err, ea.e);
                    chk("a_latency", 32'(cyc), 32'(ea.t));
                end
            end
            if (B_rvalid) begin
                if (qb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL b_unexp: rvalid rdata %h, expected none", B_rdata);
                end else begin
                    eb = qb.pop_front();
                    chk("b_rdata", B_rdata, eb.d);
                    chk1("b_err", B_err, eb.e);
                    chk("b_latency", 32'(cyc), 32'(eb.t));
                end
            end
        end
    end

    task automatic push_a(input logic [31:0] d, input logic e);
        exp_t x;
        x.d = e ? 32'h0 : (A_we ? last_a : d);
        x.e = e;
        x.t = cyc + 2;
        last_a = x.d;
        qa.push_back(x);
    endtask

    task automatic push_b(input logic [31:0] d, input logic e);
        exp_t x;
        x.d = e ? 32'h0 : (B_we ? last_b : d);
        x.e = e;
        x.t = cyc + 2;
        last_b = x.d;
        qb.push_back(x);
    endtask

    task automatic set_a(input logic we, input logic [1:0] ln,
                         input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd);
        A_req = 1'b1; A_we = we; A_len = ln;
        A_signed = sg; A_addr = ad; A_wdata = wd;
    endtask

    task automatic set_b(input logic we, input logic [1:0] ln,
                         input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd);
        B_req = 1'b1; B_we = we; B_len = ln;
        B_signed = sg; B_addr = ad; B_wdata = wd;
    endtask

    task automatic step(input logic ga, input logic gb,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic xa, input logic xb);
        @(negedge SYS_clk);
        chk1("a_gnt", A_gnt, ga);
        chk1("b_gnt", B_gnt, gb);
        if (ga) push_a(da, xa);
        if (gb) push_b(db, xb);
        @(posedge SYS_clk);
        #1;
        A_req = 1'b0;
        B_req = 1'b0;
    endtask

    initial begin
        SYS_reset = 1'b1;
        z1 = 1'b0; z2 = 2'b00; z32 = 32'h0;
        f_a_req = 1'b0; f_b_req = 1'b0;
        set_a(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        set_b(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge SYS_clk);
        #1;
        chk1("rst_a_gnt", A_gnt, 1'b0);
        chk1("rst_b_gnt", B_gnt, 1'b0);
        chk1("rst_a_rvalid", A_rvalid, 1'b0);
        chk1("rst_b_rvalid", B_rvalid, 1'b0);
        chk1("rst_a_err", A_err, 1'b0);
        chk("rst_a_rdata", A_rdata, 32'h0);
        chk("rst_b_rdata", B_rdata, 32'h0);
        chk({30'h0, MEM_write_length} == 32'h0 ? "rst_wlen" : "rst_wlen",
            {30'h0, MEM_write_length}, 32'h0);
        chk("rst_rlen", {30'h0, MEM_read_length}, 32'h0);
        chk1("rst_rsgn", MEM_read_signed, 1'b0);
        chk("rst_raddr", MEM_read_address, 32'h0);
        chk("rst_waddr", MEM_write_address, 32'h0);
        chk("rst_wdata", MEM_write_data, 32'h0);
        A_req = 1'b0;
        B_req = 1'b0;
        SYS_reset = 1'b0;

        // A store/load word
        set_a(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        set_a(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        step(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);

        // B byte store, A signed/unsigned byte loads
        set_b(1'b1, 2'b01, 1'b0, 32'h20, 32'hAAAAAA80);
        step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        set_a(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        step(1'b1, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, 1'b0);
        set_a(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        step(1'b1, 1'b0, 32'h00000080, 32'h0, 1'b0, 1'b0);

        // contention: last grant was A so B leads
        for (int i = 0; i < 4; i++) begin
            set_a(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
            set_b(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
            step(i % 2 == 1, i % 2 == 0, 32'hDEADBEEF, 32'h00007B80,
                 1'b0, 1'b0);
        end

        // range checks at MEM_LAST_BYTE = 1024
        set_a(1'b0, 2'b11, 1'b0, 32'h3FE, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        set_a(1'b1, 2'b11, 1'b0, 32'h3FE, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        set_a(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        set_a(1'b0, 2'b01, 1'b0, 32'h400, 32'h0);
        step(1'b1, 1'b0, 32'h0000005A, 32'h0, 1'b0, 1'b0);
        set_a(1'b0, 2'b10, 1'b0, 32'h3FF, 32'h0);
        step(1'b1, 1'b0, 32'h00005AA5, 32'h0, 1'b0, 1'b0);
        set_a(1'b1, 2'b00, 1'b0, 32'h3FE, 32'h11111111);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge SYS_clk);
        #1;
        for (int i = 1022; i < 1026; i++)
            chk("oob_mem", {24'h0, mem[i]}, {24'h0, init_byte(i)});

        // B back-to-back store then load half
        set_b(1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFF1234);
        step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        set_b(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        step(1'b0, 1'b1, 32'h0, 32'h00001234, 1'b0, 1'b0);

        // fixed-priority instance
        f_a_req = 1'b1;
        f_b_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge SYS_clk);
            chk1("fix_a_gnt", fx_a_gnt, 1'b1);
            chk1("fix_b_gnt", fx_b_gnt, 1'b0);
            @(posedge SYS_clk);
            #1;
        end
        f_a_req = 1'b0;
        @(negedge SYS_clk);
        chk1("fix_b_alone", fx_b_gnt, 1'b1);
        @(posedge SYS_clk);
        #1;
        f_b_req = 1'b0;

        // reset during a store's issue cycle
        repeat (3) @(posedge SYS_clk);
        #1;
        set_a(1'b1, 2'b11, 1'b0, 32'h80, 32'hCAFEF00D);
        @(negedge SYS_clk);
        chk1("mid_gnt", A_gnt, 1'b1);
        @(posedge SYS_clk);
        #2;
        SYS_reset = 1'b1;
        #1;
        chk("mid_wlen", {30'h0, MEM_write_length}, 32'h0);
        chk1("mid_a_gnt", A_gnt, 1'b0);
        chk1("mid_a_rvalid", A_rvalid, 1'b0);
        chk("mid_a_rdata", A_rdata, 32'h0);
        chk("mid_b_rdata", B_rdata, 32'h0);
        chk("mid_waddr", MEM_write_address, 32'h0);
        chk("mid_raddr", MEM_read_address, 32'h0);
        A_req = 1'b0;
        last_a = 32'h0;
        last_b = 32'h0;
        @(posedge SYS_clk);
        @(posedge SYS_clk);
        #1;
        SYS_reset = 1'b0;
        repeat (4) @(posedge SYS_clk);
        #1;
        for (int i = 128; i < 132; i++)
            chk("mid_mem", {24'h0, mem[i]}, {24'h0, init_byte(i)});

        chk("a_queue_left", 32'(qa.size()), 32'h0);
        chk("b_queue_left", 32'(qb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
